// File: rtl/ram_nxw_scrub_if.sv
// Request/response bundle for ram_nxw_scrub.
// The requester uses the master modport and the RAM uses the slave modport.
// When RAM_PARITY_EN is defined, the bundle also carries parity_err.
interface ram_nxw_scrub_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 2
);
  logic                 en;
  logic                 r_w;
  logic [ADDR_BITS-1:0] addr;
  logic [WIDTH-1:0]     din;
  logic                 flush;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic                 busy;
`ifdef RAM_PARITY_EN
  logic                 parity_err;

  modport master (
    output en, r_w, addr, din, flush,
    input  dout, dout_valid, busy, parity_err
  );
  modport slave (
    input  en, r_w, addr, din, flush,
    output dout, dout_valid, busy, parity_err
  );
`else
  modport master (
    output en, r_w, addr, din, flush,
    input  dout, dout_valid, busy
  );
  modport slave (
    input  en, r_w, addr, din, flush,
    output dout, dout_valid, busy
  );
`endif
endinterface

// File: rtl/ram_nxw_scrub.sv
// ram_nxw_scrub: single-port synchronous RAM (2**ADDR_BITS words of WIDTH bits).
//
// Reads are registered and take one cycle; dout_valid strobes with the new data.
// A scrub sequencer writes zero to every word:
//   - on the first edges after clear is released, and
//   - whenever flush is seen while idle.
// Requests that arrive while busy is high are dropped.
//
// Optional feature, macro RAM_PARITY_EN:
//   - each word carries an even-parity bit, and
//   - a registered parity_err is returned with every read.
module ram_nxw_scrub #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic           clk,
  input  logic           clear,
  ram_nxw_scrub_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] CNT_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] CNT_ONE  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] CNT_LAST = ADDR_BITS'(DEPTH - 1);
  localparam logic [WIDTH-1:0]     WORD_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_SCRUB = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic                 mem_we_s;
  logic [ADDR_BITS-1:0] mem_waddr_s;
  logic [WIDTH-1:0]     mem_wdata_s;
  logic [WIDTH-1:0]     rd_word_s;

  assign rd_word_s = mem_q[bus.addr];

`ifdef RAM_PARITY_EN
  logic                 par_q [DEPTH];
  logic                 mem_wpar_s;
  logic                 parity_err_q, parity_err_d;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // Next-state logic for the scrub/idle sequencer, the read path and the write port.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    mem_we_s     = 1'b0;
    mem_waddr_s  = bus.addr;
    mem_wdata_s  = bus.din;
`ifdef RAM_PARITY_EN
    mem_wpar_s   = even_par(bus.din);
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_SCRUB: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_q;
        mem_wdata_s = WORD_ZERO;
`ifdef RAM_PARITY_EN
        mem_wpar_s  = 1'b0;
`endif
        dout_d      = WORD_ZERO;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          busy_d = 1'b1;
        end
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.flush) begin
          // flush has priority over any request in the same cycle
          state_d = ST_SCRUB;
          cnt_d   = CNT_ZERO;
          busy_d  = 1'b1;
        end else if (bus.en) begin
          if (bus.r_w) begin
            mem_we_s = 1'b1;
          end else begin
            dout_d       = rd_word_s;
            dout_valid_d = 1'b1;
`ifdef RAM_PARITY_EN
            parity_err_d = par_q[bus.addr] ^ even_par(rd_word_s);
`endif
          end
        end else begin
          dout_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_SCRUB;
        cnt_d   = CNT_ZERO;
        busy_d  = 1'b1;
      end
    endcase
  end

  // Control and output registers; clear forces a fresh scrub from word 0.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q      <= ST_SCRUB;
      cnt_q        <= CNT_ZERO;
      dout_q       <= WORD_ZERO;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b1;
`ifdef RAM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
`ifdef RAM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage array; it is left untouched while clear is held low.
  always_ff @(posedge clk) begin
    if (clear && mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
`ifdef RAM_PARITY_EN
      par_q[mem_waddr_s] <= mem_wpar_s;
`endif
    end else begin
      mem_q[mem_waddr_s] <= mem_q[mem_waddr_s];
`ifdef RAM_PARITY_EN
      par_q[mem_waddr_s] <= par_q[mem_waddr_s];
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
`ifdef RAM_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ram_nxw_scrub.sv
// Testbench for ram_nxw_scrub.
// It uses two instances: 8x4 (WIDTH=8, ADDR_BITS=2) and 16x16 (WIDTH=16, ADDR_BITS=4).
// Each read request pushes its expected {parity_err, dout} into a queue.
// A negedge monitor pops the queue and compares whenever dout_valid is high.
// A dout_valid with an empty queue is reported as a failure.
module tb_ram_nxw_scrub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear8;
  logic clear16;

  ram_nxw_scrub_if #(.WIDTH(8),  .ADDR_BITS(2)) i8 ();
  ram_nxw_scrub_if #(.WIDTH(16), .ADDR_BITS(4)) i16 ();

  ram_nxw_scrub #(.WIDTH(8), .ADDR_BITS(2)) dut8 (
    .clk  (clk),
    .clear(clear8),
    .bus  (i8.slave)
  );
  ram_nxw_scrub #(.WIDTH(16), .ADDR_BITS(4)) dut16 (
    .clk  (clk),
    .clear(clear16),
    .bus  (i16.slave)
  );

  logic p8_s;
  logic p16_s;
`ifdef RAM_PARITY_EN
  assign p8_s  = i8.parity_err;
  assign p16_s = i16.parity_err;
`else
  assign p8_s  = 1'b0;
  assign p16_s = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [8:0]  q8  [$];
  logic [16:0] q16 [$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the 8-bit instance.
  always @(negedge clk) begin
    logic [8:0] e;
    if (i8.dout_valid !== 1'b0) begin
      tests++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid8: got dout 0x%0h with no read pending", i8.dout);
      end else begin
        e = q8.pop_front();
        if ({p8_s, i8.dout} !== e) begin
          fails++;
          $display("FAIL read8: got {perr,dout} 0x%0h, expected 0x%0h", {p8_s, i8.dout}, e);
        end
      end
    end
  end

  // Scoreboard monitor for the 16-bit instance.
  always @(negedge clk) begin
    logic [16:0] e;
    if (i16.dout_valid !== 1'b0) begin
      tests++;
      if (q16.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid16: got dout 0x%0h with no read pending", i16.dout);
      end else begin
        e = q16.pop_front();
        if ({p16_s, i16.dout} !== e) begin
          fails++;
          $display("FAIL read16: got {perr,dout} 0x%0h, expected 0x%0h", {p16_s, i16.dout}, e);
        end
      end
    end
  end

  task automatic wr8(input logic [1:0] a, input logic [7:0] d);
    i8.en = 1'b1; i8.r_w = 1'b1; i8.addr = a; i8.din = d;
    cyc();
    i8.en = 1'b0;
  endtask

  task automatic rd8(input logic [1:0] a, input logic [7:0] exp);
    i8.en = 1'b1; i8.r_w = 1'b0; i8.addr = a;
    q8.push_back({1'b0, exp});
    cyc();
    i8.en = 1'b0;
  endtask

  task automatic wr16(input logic [3:0] a, input logic [15:0] d);
    i16.en = 1'b1; i16.r_w = 1'b1; i16.addr = a; i16.din = d;
    cyc();
    i16.en = 1'b0;
  endtask

  task automatic rd16(input logic [3:0] a, input logic [15:0] exp, input logic perr);
    i16.en = 1'b1; i16.r_w = 1'b0; i16.addr = a;
    q16.push_back({perr, exp});
    cyc();
    i16.en = 1'b0;
  endtask

  task automatic busy_run8(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, {31'd0, i8.busy}, 32'd1);
      cyc();
    end
    check({name, "_drop"}, {31'd0, i8.busy}, 32'd0);
  endtask

  task automatic busy_run16(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, {31'd0, i16.busy}, 32'd1);
      cyc();
    end
    check({name, "_drop"}, {31'd0, i16.busy}, 32'd0);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (i8.busy !== 1'b0 && n < 64) begin
      cyc();
      n++;
    end
    check("idle8_timeout", {31'd0, i8.busy}, 32'd0);
  endtask

  task automatic flush8();
    i8.flush = 1'b1;
    cyc();
    i8.flush = 1'b0;
  endtask

  initial begin
    clear8 = 1'b0; clear16 = 1'b0;
    i8.en = 1'b0;  i8.r_w = 1'b0;  i8.addr = 2'd0;  i8.din = 8'd0;   i8.flush = 1'b0;
    i16.en = 1'b0; i16.r_w = 1'b0; i16.addr = 4'd0; i16.din = 16'd0; i16.flush = 1'b0;

    // Reset state, then the scrub that follows release.
    repeat (3) cyc();
    check("reset_dout",   {24'd0, i8.dout},        32'd0);
    check("reset_valid",  {31'd0, i8.dout_valid},  32'd0);
    check("reset_busy",   {31'd0, i8.busy},        32'd1);
    check("reset_busy16", {31'd0, i16.busy},       32'd1);
    clear8 = 1'b1; clear16 = 1'b1;
    busy_run8("scrub_busy", 4);
    busy_run16("scrub16_busy", 12);

    // Every word reads back as zero after the scrub.
    for (int a = 0; a < 4; a++) rd8(a[1:0], 8'h00);

    // Write two words, then read them back-to-back.
    wr8(2'd1, 8'hA5);
    check("write_no_valid", {31'd0, i8.dout_valid}, 32'd0);
    wr8(2'd2, 8'h3C);
    rd8(2'd1, 8'hA5);
    check("b2b_valid1", {31'd0, i8.dout_valid}, 32'd1);
    rd8(2'd2, 8'h3C);
    check("b2b_valid2", {31'd0, i8.dout_valid}, 32'd1);
    cyc();
    check("b2b_valid_end", {31'd0, i8.dout_valid}, 32'd0);
    check("dout_hold", {24'd0, i8.dout}, 32'h3C);
    wr8(2'd0, 8'h5A);
    rd8(2'd0, 8'h5A);

    // A write issued on scrub cycle 2 is dropped.
    flush8();
    check("flush_busy_now", {31'd0, i8.busy}, 32'd1);
    cyc();
    wr8(2'd3, 8'hFF);
    wait_idle8();
    rd8(2'd3, 8'h00);
    rd8(2'd1, 8'h00);

    // flush and a read in the same cycle: flush wins and no strobe appears.
    for (int a = 0; a < 4; a++) wr8(a[1:0], 8'h55);
    rd8(2'd2, 8'h55);
    cyc();
    i8.flush = 1'b1; i8.en = 1'b1; i8.r_w = 1'b0; i8.addr = 2'd0;
    cyc();
    i8.flush = 1'b0; i8.en = 1'b0;
    check("collision_valid", {31'd0, i8.dout_valid}, 32'd0);
    busy_run8("collision_busy", 4);
    rd8(2'd0, 8'h00);
    rd8(2'd2, 8'h00);

    // flush during a scrub is ignored, so the scrub keeps its length.
    flush8();
    cyc();
    i8.flush = 1'b1;
    cyc();
    i8.flush = 1'b0;
    busy_run8("flush_ignored", 2);

    // Pulse clear on scrub cycle 2: the scrub restarts and dout stays zero.
    wr8(2'd0, 8'h77);
    rd8(2'd0, 8'h77);
    flush8();
    cyc();
    clear8 = 1'b0;
    cyc();
    clear8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("midreset_busy",  {31'd0, i8.busy},       32'd1);
      check("midreset_dout",  {24'd0, i8.dout},       32'd0);
      check("midreset_valid", {31'd0, i8.dout_valid}, 32'd0);
      cyc();
    end
    check("midreset_drop", {31'd0, i8.busy}, 32'd0);

    // clear in the same cycle as a read cancels the read strobe.
    i8.en = 1'b1; i8.r_w = 1'b0; i8.addr = 2'd1; clear8 = 1'b0;
    cyc();
    i8.en = 1'b0; clear8 = 1'b1;
    check("cancel_valid", {31'd0, i8.dout_valid}, 32'd0);
    check("cancel_busy",  {31'd0, i8.busy},       32'd1);
    wait_idle8();

    // Wide, deep instance: top address round trip.
    wr16(4'd15, 16'hBEEF);
    rd16(4'd15, 16'hBEEF, 1'b0);
    rd16(4'd0, 16'h0000, 1'b0);
    cyc();
`ifdef RAM_PARITY_EN
    dut16.mem_q[15][0] = ~dut16.mem_q[15][0];
    rd16(4'd15, 16'hBEEE, 1'b1);
    cyc();
`endif

    repeat (2) cyc();
    check("q8_drained",  q8.size(),  32'd0);
    check("q16_drained", q16.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
